stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of every data bus.
REQ-002 Port: clk input 1, single clock; all logic on rising edge.
REQ-003 Port: reset input 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 Port: select input 1, route request; 0 = output 1, 1 = output 2.
REQ-005 Port: s_data input DATA_WIDTH, slave-side stream data.
REQ-006 Port: s_valid input 1, slave-side beat valid.
REQ-007 Port: s_ready output 1, slave-side ready.
REQ-008 Port: s_last input 1, slave-side final beat of packet.
REQ-009 Port: m1_data output DATA_WIDTH, output-1 data.
REQ-010 Port: m1_valid output 1, output-1 valid.
REQ-011 Port: m1_ready input 1, output-1 ready.
REQ-012 Port: m1_last output 1, output-1 last.
REQ-013 Port: m2_data, m2_valid, m2_ready, m2_last; same widths, directions and meanings as output 1, for output 2.
REQ-014 Port: pkt_cnt1 output 8, packets completed on output 1.
REQ-015 Port: pkt_cnt2 output 8, packets completed on output 2.

Function
REQ-016 A beat SHALL transfer on any interface only in a cycle where valid and ready are both 1 at the rising edge of clk.
REQ-017 The routing FSM SHALL have the states IDLE, PKT1 and PKT2; the reset state is IDLE.
REQ-018 In IDLE, the route SHALL be taken from select in the same cycle as the first accepted beat.
- select=0: first beat goes to output 1; next state PKT1 if s_last=0, else stay IDLE.
- select=1: same, for output 2 / PKT2.
REQ-019 In PKT1 or PKT2, the route SHALL stay locked; select changes are ignored until the beat with s_last=1 is accepted.
REQ-020 In PKT1 or PKT2, acceptance of the beat with s_last=1 SHALL return the FSM to IDLE.
REQ-021 Each output SHALL have a one-entry output register holding data, last and valid.
REQ-022 An accepted beat SHALL appear on the routed output the cycle after acceptance (latency 1), with data and last unchanged.
REQ-023 s_ready SHALL equal (~mX_valid | mX_ready) for the current route X, combinationally.
- In IDLE, the current route X is given by select.
- In PKT1 or PKT2, X is the locked output.
REQ-024 The output not routed SHALL never receive a beat, and its ready SHALL have no effect on s_ready.
REQ-025 mX_valid SHALL stay high, with data and last stable, until mX_ready=1 (no retraction under back-pressure).
REQ-026 When an output register drains and refills in the same cycle, the new beat SHALL load with no bubble.
- Full throughput: 1 beat/cycle when mX_ready stays high.
REQ-027 Both outputs MAY hold valid beats at the same time, one from a previous packet and one from the current packet, and each SHALL drain independently.
REQ-028 pkt_cntX SHALL increment by 1 when a beat with mX_last=1 transfers on output X, and SHALL wrap from 255 to 0.
REQ-029 The packet counters SHALL increment independently; simultaneous last transfers on both outputs SHALL increment both counters in that cycle.
REQ-030 A single-beat packet (s_last=1 on the first beat) SHALL be routed by select and SHALL leave the FSM in IDLE.

Reset
REQ-031 reset=0 SHALL immediately clear, without waiting for clk:
- FSM to IDLE.
- m1_valid, m2_valid, m1_last, m2_last to 0.
- m1_data, m2_data to 0.
- pkt_cnt1, pkt_cnt2 to 0.
REQ-032 While reset=0, s_ready SHALL be 0.
REQ-033 A reset asserted mid-packet SHALL discard all buffered beats, with no partial-packet completion and no counter increment.
REQ-034 After reset deasserts, the first accepted beat SHALL be treated as a packet start.

Verification
REQ-035 Reset: hold reset=0 for 2 cycles with s_valid=1 -> s_ready=0, both mX_valid=0, both counters=0.
REQ-036 Route 1: select=0, send a 4-beat packet 0xA1..0xA4 with m1_ready=1 -> m1 shows 0xA1..0xA4 one cycle after each beat, last on 0xA4, pkt_cnt1=1, m2_valid stays 0.
REQ-037 Route lock: select=1 at beat 1 of a 7-beat packet, toggled to 0 at beat 3 -> all 7 beats on m2, pkt_cnt2 increments once, then the next packet follows the new select.
REQ-038 Back-pressure: m2_ready=0 for 5 cycles mid-packet -> m2 data holds stable, s_ready=0 until m2_ready=1, no beat lost or duplicated.
REQ-039 Overlap: output-1 last beat stalled (m1_ready=0) while a packet streams to output 2 with m2_ready=1 -> the output-2 packet completes and pkt_cnt2 increments; pkt_cnt1 increments when m1_ready rises.
REQ-040 Wrap and reset mid-packet: 256 single-beat packets to output 1 -> pkt_cnt1=0 again; then reset=0 during beat 2 of a packet -> outputs clear at once, counters=0, and the next beat starts a new packet.

Source files
------------

// File: rtl/stream_demux.sv
// Purpose: routes whole packets from one input stream to output 1 or 2, chosen by select at the first beat.
// Latency: 1 cycle from input acceptance to the routed output register; sustains 1 beat/cycle.
// Backpressure: s_ready = routed output register empty or draining; the unrouted output never stalls the input.
module stream_demux #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  select,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] m1_data,
    output logic                  m1_valid,
    input  logic                  m1_ready,
    output logic                  m1_last,
    output logic [DATA_WIDTH-1:0] m2_data,
    output logic                  m2_valid,
    input  logic                  m2_ready,
    output logic                  m2_last,
    output logic [7:0]            pkt_cnt1,
    output logic [7:0]            pkt_cnt2
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT1 = 2'd1,
        PKT2 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_route;     // 0 = output 1, 1 = output 2
    logic                  w_m1_free;
    logic                  w_m2_free;
    logic                  w_acc;
    logic                  w_acc1;
    logic                  w_acc2;
    logic [DATA_WIDTH-1:0] r_m1_data;
    logic [DATA_WIDTH-1:0] r_m2_data;
    logic                  r_m1_valid;
    logic                  r_m2_valid;
    logic                  r_m1_last;
    logic                  r_m2_last;
    logic [7:0]            r_cnt1;
    logic [7:0]            r_cnt2;

    // Route: live select while idle, otherwise the output locked at packet start.
    assign w_route   = (r_state == PKT2) ? 1'b1 :
                       (r_state == PKT1) ? 1'b0 : select;

    // An output register can take a beat if it is empty or being drained this cycle.
    assign w_m1_free = ~r_m1_valid | m1_ready;
    assign w_m2_free = ~r_m2_valid | m2_ready;

    // Reset gates ready so nothing is accepted while reset is held.
    assign s_ready   = reset & (w_route ? w_m2_free : w_m1_free);
    assign w_acc     = s_valid & s_ready;
    assign w_acc1    = w_acc & ~w_route;
    assign w_acc2    = w_acc & w_route;

    // Routing state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: lock on a non-final first beat, unlock when the final beat is accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_acc && !s_last) begin
                    w_state_nxt = select ? PKT2 : PKT1;
                end
            end
            PKT1, PKT2: begin
                if (w_acc && s_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output-1 register: load on routed accept (drain+refill in one cycle), clear valid on drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m1_valid <= 1'b0;
            r_m1_data  <= '0;
            r_m1_last  <= 1'b0;
        end else if (w_acc1) begin
            r_m1_valid <= 1'b1;
            r_m1_data  <= s_data;
            r_m1_last  <= s_last;
        end else if (m1_ready) begin
            r_m1_valid <= 1'b0;
        end
    end

    // Output-2 register: same behaviour as output 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m2_valid <= 1'b0;
            r_m2_data  <= '0;
            r_m2_last  <= 1'b0;
        end else if (w_acc2) begin
            r_m2_valid <= 1'b1;
            r_m2_data  <= s_data;
            r_m2_last  <= s_last;
        end else if (m2_ready) begin
            r_m2_valid <= 1'b0;
        end
    end

    // Packet counters: count final beats actually leaving each output; wrap at 8 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt1 <= 8'd0;
            r_cnt2 <= 8'd0;
        end else begin
            if (r_m1_valid && m1_ready && r_m1_last) begin
                r_cnt1 <= r_cnt1 + 8'd1;
            end
            if (r_m2_valid && m2_ready && r_m2_last) begin
                r_cnt2 <= r_cnt2 + 8'd1;
            end
        end
    end

    assign m1_data  = r_m1_data;
    assign m1_valid = r_m1_valid;
    assign m1_last  = r_m1_last;
    assign m2_data  = r_m2_data;
    assign m2_valid = r_m2_valid;
    assign m2_last  = r_m2_last;
    assign pkt_cnt1 = r_cnt1;
    assign pkt_cnt2 = r_cnt2;

endmodule

// File: tb/tb_stream_demux.sv
// Purpose: self-checking bench for stream_demux against a queue-based packet routing model.
// Latency: model expects each accepted beat at the front of its output queue one cycle later.
// Backpressure: model predicts s_ready from output occupancy and the routed output's ready.
module tb_stream_demux;

    logic       clk;
    logic       reset;
    logic       select;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       s_last;
    logic [7:0] m1_data;
    logic       m1_valid;
    logic       m1_ready;
    logic       m1_last;
    logic [7:0] m2_data;
    logic       m2_valid;
    logic       m2_ready;
    logic       m2_last;
    logic [7:0] pkt_cnt1;
    logic [7:0] pkt_cnt2;

    stream_demux #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .select   (select),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .m1_data  (m1_data),
        .m1_valid (m1_valid),
        .m1_ready (m1_ready),
        .m1_last  (m1_last),
        .m2_data  (m2_data),
        .m2_valid (m2_valid),
        .m2_ready (m2_ready),
        .m2_last  (m2_last),
        .pkt_cnt1 (pkt_cnt1),
        .pkt_cnt2 (pkt_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one queue of pending beats per output, packet counters, route lock.
    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      q1[$];
    beat_t      q2[$];
    logic [7:0] e_cnt1;
    logic [7:0] e_cnt2;
    bit         m_locked;
    bit         m_lock2;
    bit         g_r1;
    bit         g_r2;
    int         n_vec;
    int         n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q1.delete();
        q2.delete();
        e_cnt1   = 8'd0;
        e_cnt2   = 8'd0;
        m_locked = 1'b0;
        m_lock2  = 1'b0;
    endtask

    task automatic reset_chk();
        chk("rst_s_ready",  s_ready,  0);
        chk("rst_m1_valid", m1_valid, 0);
        chk("rst_m2_valid", m2_valid, 0);
        chk("rst_m1_last",  m1_last,  0);
        chk("rst_m2_last",  m2_last,  0);
        chk("rst_m1_data",  m1_data,  0);
        chk("rst_m2_data",  m2_data,  0);
        chk("rst_cnt1",     pkt_cnt1, 0);
        chk("rst_cnt2",     pkt_cnt2, 0);
    endtask

    task automatic drive(input bit v, input bit sel, input logic [7:0] d, input bit l,
                         input bit r1, input bit r2);
        s_valid  = v;
        select   = sel;
        s_data   = d;
        s_last   = l;
        m1_ready = r1;
        m2_ready = r2;
    endtask

    // Check the current cycle against the model, advance the model past the next edge.
    task automatic step(output bit acc);
        bit    route2;
        bit    er;
        beat_t b;
        #1;
        route2 = m_locked ? m_lock2 : select;
        er = reset && (route2 ? (q2.size() == 0 || m2_ready) : (q1.size() == 0 || m1_ready));
        chk("s_ready",  s_ready,  er);
        chk("m1_valid", m1_valid, q1.size() != 0);
        chk("m2_valid", m2_valid, q2.size() != 0);
        if (q1.size() != 0) begin
            chk("m1_data", m1_data, q1[0].d);
            chk("m1_last", m1_last, q1[0].l);
        end
        if (q2.size() != 0) begin
            chk("m2_data", m2_data, q2[0].d);
            chk("m2_last", m2_last, q2[0].l);
        end
        chk("pkt_cnt1", pkt_cnt1, e_cnt1);
        chk("pkt_cnt2", pkt_cnt2, e_cnt2);
        acc = er && s_valid;
        if (reset) begin
            if (q1.size() != 0 && m1_ready) begin
                if (q1[0].l) e_cnt1++;
                void'(q1.pop_front());
            end
            if (q2.size() != 0 && m2_ready) begin
                if (q2[0].l) e_cnt2++;
                void'(q2.pop_front());
            end
            if (acc) begin
                b.d = s_data;
                b.l = s_last;
                if (route2) q2.push_back(b);
                else        q1.push_back(b);
                if (!m_locked && !s_last) begin
                    m_locked = 1'b1;
                    m_lock2  = route2;
                end else if (m_locked && s_last) begin
                    m_locked = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, g_r1, g_r2);
            step(acc);
        end
    endtask

    // Send an n-beat packet; select switches from sel0 to sel1 at beat sw_at; the chosen
    // output's ready is forced low for packet-relative cycles [st_lo, st_hi).
    task automatic send_pkt(input int n, input logic [7:0] base, input bit sel0, input bit sel1,
                            input int sw_at, input int st_lo, input int st_hi, input bit st_m2);
        bit acc;
        bit r1;
        bit r2;
        int c;
        int tries;
        c = 0;
        for (int i = 0; i < n; i++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 40) begin
                r1 = g_r1;
                r2 = g_r2;
                if (c >= st_lo && c < st_hi) begin
                    if (st_m2) r2 = 1'b0;
                    else       r1 = 1'b0;
                end
                drive(1'b1, (i < sw_at) ? sel0 : sel1, base + 8'(i), (i == n - 1), r1, r2);
                step(acc);
                c++;
                tries++;
            end
            if (!acc) begin
                n_vec++;
                n_err++;
                $error("FAIL send_timeout beat=%0d observed=stalled expected=accepted", i);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         acc;
        logic [7:0] c0;
        logic [7:0] c1;
        n_vec = 0;
        n_err = 0;
        g_r1  = 1'b1;
        g_r2  = 1'b1;
        model_clear();
        reset = 1'b0;
        drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1);

        // Reset held two cycles with valid input.
        @(negedge clk);
        reset_chk();
        step(acc);
        reset_chk();
        step(acc);
        reset = 1'b1;

        // Route 1: four beats A1..A4 to output 1.
        send_pkt(4, 8'hA1, 1'b0, 1'b0, 99, 0, 0, 1'b0);
        idle(2);
        chk("route1_cnt1", pkt_cnt1, 1);
        chk("route1_cnt2", pkt_cnt2, 0);

        // Route lock: select 1 at start, 0 from beat 3; all seven beats must go to output 2.
        send_pkt(7, 8'h10, 1'b1, 1'b0, 2, 0, 0, 1'b0);
        idle(2);
        chk("lock_cnt2", pkt_cnt2, 1);
        chk("lock_cnt1", pkt_cnt1, 1);
        send_pkt(1, 8'h30, 1'b0, 1'b0, 99, 0, 0, 1'b0);
        idle(2);
        chk("lock_next_cnt1", pkt_cnt1, 2);

        // Back-pressure: output 2 stalled for five cycles mid-packet.
        send_pkt(6, 8'h40, 1'b1, 1'b1, 99, 2, 7, 1'b1);
        idle(2);
        chk("bp_cnt2", pkt_cnt2, 2);

        // Overlap: output-1 last beat held while a packet streams to output 2.
        send_pkt(2, 8'h50, 1'b0, 1'b0, 99, 0, 0, 1'b0);
        g_r1 = 1'b0;
        send_pkt(3, 8'h60, 1'b1, 1'b1, 99, 0, 0, 1'b0);
        idle(2);
        chk("ovl_cnt2", pkt_cnt2, 3);
        chk("ovl_cnt1_held", pkt_cnt1, 2);
        chk("ovl_m1_pending", m1_valid, 1);
        g_r1 = 1'b1;
        idle(2);
        chk("ovl_cnt1", pkt_cnt1, 3);

        // Randomised traffic with random back-pressure on both outputs.
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0));
            step(acc);
        end
        // Close any open packet, then drain.
        send_pkt(1, 8'hEE, 1'b0, 1'b0, 99, 0, 0, 1'b0);
        idle(3);

        // Wrap: 256 single-beat packets to output 1 bring the counter back to its start value.
        c0 = e_cnt1;
        c1 = pkt_cnt1;
        chk("wrap_start", c1, c0);
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b1, 1'b1);
            step(acc);
        end
        idle(2);
        chk("wrap_cnt1", pkt_cnt1, c1);

        // Reset during beat 2 of a packet to output 2.
        drive(1'b1, 1'b1, 8'h71, 1'b0, 1'b1, 1'b1);
        step(acc);
        drive(1'b1, 1'b1, 8'h72, 1'b0, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        reset_chk();
        model_clear();
        step(acc);
        reset_chk();
        reset = 1'b1;
        // First beat after reset is a new packet start, routed by select.
        drive(1'b1, 1'b0, 8'h81, 1'b1, 1'b1, 1'b1);
        step(acc);
        chk("post_rst_acc", acc, 1);
        idle(2);
        chk("post_rst_cnt1", pkt_cnt1, 1);
        chk("post_rst_cnt2", pkt_cnt2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
